// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - host byte-stream parser into next_target, committed to target on latch
module frame_loader #(
  parameter int         c_ledboards = 30,
  parameter int         c_bpc       = 12,
  parameter int         c_max_time  = 1024,
  parameter logic [7:0] c_sync      = 8'hA5,
  localparam int        c_channels  = 32 * c_ledboards,
  localparam int        c_time_w    = $clog2(c_max_time),
  localparam int        c_addr_w    = $clog2(c_channels)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_sof,
  input  logic                i_valid,
  input  logic [7:0]          i_data,
  output logic                o_ready,
  input  logic                i_drq,
  output logic                o_wen,
  output logic [c_addr_w-1:0] o_waddr,
  output logic [c_bpc-1:0]    o_wdata,
  output logic [c_time_w-1:0] o_time,
  output logic [c_addr_w-1:0] o_raddr,
  input  logic [c_bpc-1:0]    i_rdata,
  output logic                o_twen,
  output logic [c_addr_w-1:0] o_twaddr,
  output logic [c_bpc-1:0]    o_twdata,
  output logic [c_time_w-1:0] o_ttime,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  // Channels are handled in pairs of three bytes; the pair index drives the write address.
  localparam int c_pair_w = $clog2(c_channels / 2);
  // The copy counter must reach c_channels to cover the trailing delayed write.
  localparam int c_cnt_w  = $clog2(c_channels + 1);

  localparam logic [c_pair_w-1:0] c_last_pair = c_pair_w'(c_channels / 2 - 1);
  localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(c_channels - 1);
  localparam logic [c_cnt_w-1:0]  c_copy_end  = c_cnt_w'(c_channels);
  localparam logic [15:0]         c_time_lim  = 16'(c_max_time);
  localparam logic [c_time_w-1:0] c_time_max  = c_time_w'(c_max_time - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TIME_H = 3'd1,
    TIME_L = 3'd2,
    D0     = 3'd3,
    D1     = 3'd4,
    D2     = 3'd5,
    PEND   = 3'd6,
    COPY   = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [c_pair_w-1:0] k_q, k_d;
  logic [7:0]          b0_q, b0_d;
  logic [3:0]          b1lo_q, b1lo_d;
  logic [7:0]          thi_q, thi_d;
  logic [c_time_w-1:0] time_q, time_d;
  logic                wen_q, wen_d;
  logic [c_addr_w-1:0] waddr_q, waddr_d;
  logic [c_bpc-1:0]    wdata_q, wdata_d;
  logic [c_addr_w-1:0] raddr_q, raddr_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic                twen_q, twen_d;
  logic [c_addr_w-1:0] twaddr_q, twaddr_d;
  logic [c_time_w-1:0] ttime_q, ttime_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                ready;
  logic                accept;
  logic                receiving;
  logic [15:0]         tval;

  // Ready and busy are pure state decodes so the host sees backpressure only while a frame is held.
  always_comb begin
    ready     = (state_q != PEND) && (state_q != COPY);
    accept    = i_valid && ready;
    receiving = (state_q == TIME_H) || (state_q == TIME_L) ||
                (state_q == D0) || (state_q == D1) || (state_q == D2);
    tval      = {thi_q, i_data};
  end

  // Next-state and registered-output computation for the parser and the commit copy.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    b0_d     = b0_q;
    b1lo_d   = b1lo_q;
    thi_d    = thi_q;
    time_d   = time_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    raddr_d  = raddr_q;
    cnt_d    = cnt_q;
    twen_d   = 1'b0;
    twaddr_d = twaddr_q;
    ttime_d  = ttime_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (receiving && i_sof) begin
      // A new chip-select mid-packet drops the partial frame; the same-cycle byte may start a new one.
      err_d = 1'b1;
      k_d   = '0;
      if (i_valid && (i_data == c_sync)) begin
        state_d = TIME_H;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (i_data == c_sync) begin
              state_d = TIME_H;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        TIME_H: begin
          if (accept) begin
            thi_d   = i_data;
            state_d = TIME_L;
          end
        end
        TIME_L: begin
          if (accept) begin
            if (tval >= c_time_lim) begin
              time_d = c_time_max;
            end else begin
              time_d = tval[c_time_w-1:0];
            end
            k_d     = '0;
            state_d = D0;
          end
        end
        D0: begin
          if (accept) begin
            b0_d    = i_data;
            state_d = D1;
          end
        end
        D1: begin
          if (accept) begin
            wen_d   = 1'b1;
            waddr_d = c_addr_w'({k_q, 1'b0});
            wdata_d = {b0_q, i_data[7:4]};
            b1lo_d  = i_data[3:0];
            state_d = D2;
          end
        end
        D2: begin
          if (accept) begin
            wen_d   = 1'b1;
            waddr_d = c_addr_w'({k_q, 1'b1});
            wdata_d = {b1lo_q, i_data};
            if (k_q == c_last_pair) begin
              state_d = PEND;
            end else begin
              k_d     = k_q + 1'b1;
              state_d = D0;
            end
          end
        end
        PEND: begin
          if (i_drq) begin
            raddr_d = '0;
            cnt_d   = '0;
            ttime_d = time_q;
            state_d = COPY;
          end
        end
        COPY: begin
          // Target write trails the read address by one cycle to match the RAM latency.
          twaddr_d = raddr_q;
          if (cnt_q == c_copy_end) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            raddr_d = '0;
            state_d = IDLE;
          end else begin
            twen_d = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (raddr_q != c_last_addr) begin
              raddr_d = raddr_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; reset clears everything immediately, even mid-copy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      b0_q     <= '0;
      b1lo_q   <= '0;
      thi_q    <= '0;
      time_q   <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      raddr_q  <= '0;
      cnt_q    <= '0;
      twen_q   <= 1'b0;
      twaddr_q <= '0;
      ttime_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      b0_q     <= b0_d;
      b1lo_q   <= b1lo_d;
      thi_q    <= thi_d;
      time_q   <= time_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      raddr_q  <= raddr_d;
      cnt_q    <= cnt_d;
      twen_q   <= twen_d;
      twaddr_q <= twaddr_d;
      ttime_q  <= ttime_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Read data passes straight to the target only while a target write is active.
  always_comb begin
    o_ready  = ready;
    o_busy   = (state_q == PEND) || (state_q == COPY);
    o_wen    = wen_q;
    o_waddr  = waddr_q;
    o_wdata  = wdata_q;
    o_time   = time_q;
    o_raddr  = raddr_q;
    o_twen   = twen_q;
    o_twaddr = twaddr_q;
    o_twdata = twen_q ? i_rdata : '0;
    o_ttime  = ttime_q;
    o_done   = done_q;
    o_err    = err_q;
  end

endmodule

// File: tb/tb_frame_loader.sv
// tb/tb_frame_loader.sv - directed self-checking bench for frame_loader
module tb_frame_loader;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_sof;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        o_ready;
  logic        i_drq;
  logic        o_wen;
  logic [9:0]  o_waddr;
  logic [11:0] o_wdata;
  logic [9:0]  o_time;
  logic [9:0]  o_raddr;
  logic [11:0] i_rdata;
  logic        o_twen;
  logic [9:0]  o_twaddr;
  logic [11:0] o_twdata;
  logic [9:0]  o_ttime;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  frame_loader dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_sof    (i_sof),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .i_drq    (i_drq),
    .o_wen    (o_wen),
    .o_waddr  (o_waddr),
    .o_wdata  (o_wdata),
    .o_time   (o_time),
    .o_raddr  (o_raddr),
    .i_rdata  (i_rdata),
    .o_twen   (o_twen),
    .o_twaddr (o_twaddr),
    .o_twdata (o_twdata),
    .o_ttime  (o_ttime),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_err    (o_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  logic [11:0] nt_mem [960];
  logic [11:0] t_mem  [960];
  int          wen_cnt   = 0;
  int          twen_cnt  = 0;
  int          bad_waddr = 0;

  // Framebuffer models with 1-cycle read latency, plus write counters.
  always @(posedge i_clk) begin
    i_rdata <= nt_mem[o_raddr];
    if (o_wen) begin
      nt_mem[o_waddr] <= o_wdata;
      wen_cnt <= wen_cnt + 1;
      if (o_waddr > 10'd959) bad_waddr <= bad_waddr + 1;
    end
    if (o_twen) begin
      t_mem[o_twaddr] <= o_twdata;
      twen_cnt <= twen_cnt + 1;
    end
  end

  int n_pass  = 0;
  int n_total = 0;
  int rdy_low = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] b, input logic sof, input logic drq);
    i_valid = 1'b1;
    i_data  = b;
    i_sof   = sof;
    i_drq   = drq;
    if (!o_ready) rdy_low++;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_drq   = 1'b0;
  endtask

  // Channel i carries 12'h100 + i.
  task automatic send_frame(input logic drq_last);
    logic [11:0] a, b;
    for (int k = 0; k < 480; k++) begin
      a = 12'h100 + 12'(2 * k);
      b = a + 12'h1;
      send(a[11:4], 1'b0, 1'b0);
      send({a[3:0], b[11:8]}, 1'b0, 1'b0);
      send(b[7:0], 1'b0, drq_last && (k == 479));
    end
  endtask

  task automatic pulse_drq();
    i_drq = 1'b1;
    @(posedge i_clk);
    #1;
    i_drq = 1'b0;
  endtask

  int base_w, base_t, n, bad, raddr_bad, tw_bad, ttime_bad, rdy_bad;

  initial begin
    i_rst_n = 1'b0;
    i_sof   = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_drq   = 1'b0;
    @(posedge i_clk);
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_time", o_time, 0);
    chk("rst_wen", o_wen, 0);
    chk("rst_raddr", o_raddr, 0);
    chk("rst_err", o_err, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Bad sync byte
    send(8'h00, 1'b0, 1'b0);
    chk("badsync_err", o_err, 1);
    chk("badsync_ready", o_ready, 1);
    @(posedge i_clk);
    #1;
    chk("badsync_err_clr", o_err, 0);

    // Time clamp cases
    send(8'hA5, 1'b0, 1'b0); send(8'h12, 1'b0, 1'b0); send(8'h34, 1'b0, 1'b0);
    chk("time_1234", o_time, 1023);
    send(8'hA5, 1'b1, 1'b0);
    chk("sof_abort_err", o_err, 1);
    send(8'h03, 1'b0, 1'b0); send(8'hFF, 1'b0, 1'b0);
    chk("time_03ff", o_time, 1023);
    send(8'hA5, 1'b1, 1'b0); send(8'h03, 1'b0, 1'b0); send(8'hFE, 1'b0, 1'b0);
    chk("time_03fe", o_time, 1022);

    // Full packet, drq coincident with the last byte
    send(8'hA5, 1'b1, 1'b0); send(8'h00, 1'b0, 1'b0); send(8'h64, 1'b0, 1'b0);
    chk("time_100", o_time, 100);
    base_w  = wen_cnt;
    base_t  = twen_cnt;
    rdy_low = 0;
    send_frame(1'b1);
    chk("pend_busy", o_busy, 1);
    chk("pend_ready", o_ready, 0);
    repeat (5) @(posedge i_clk);
    #1;
    chk("pend_hold", o_busy, 1);
    chk("pend_no_twen", twen_cnt - base_t, 0);
    chk("frame_writes", wen_cnt - base_w, 960);
    chk("waddr_range", bad_waddr, 0);
    chk("ready_during_rx", rdy_low, 0);
    bad = 0;
    for (int i = 0; i < 960; i++) if (nt_mem[i] !== 12'(12'h100 + i)) bad++;
    chk("nt_contents", bad, 0);

    // Commit copy
    pulse_drq();
    chk("copy_raddr0", o_raddr, 0);
    n = 0; raddr_bad = 0; tw_bad = 0; ttime_bad = 0; rdy_bad = 0;
    while (!o_done && n < 2000) begin
      if (o_raddr != 10'((n <= 959) ? n : 959)) raddr_bad++;
      if (o_twen != ((n >= 1) && (n <= 960))) tw_bad++;
      else if (o_twen && (o_twaddr != 10'(n - 1))) tw_bad++;
      if (o_ttime != 10'd100) ttime_bad++;
      if (o_ready || !o_busy) rdy_bad++;
      i_drq = (n == 100);
      @(posedge i_clk);
      #1;
      i_drq = 1'b0;
      n++;
    end
    chk("done_latency", n, 961);
    chk("copy_raddr_seq", raddr_bad, 0);
    chk("copy_twrite_seq", tw_bad, 0);
    chk("copy_ttime", ttime_bad, 0);
    chk("copy_ready_busy", rdy_bad, 0);
    chk("done_idle_ready", o_ready, 1);
    bad = 0;
    for (int i = 0; i < 960; i++) if (t_mem[i] !== 12'(12'h100 + i)) bad++;
    chk("target_contents", bad, 0);

    // Abort after 500 data bytes
    send(8'hA5, 1'b0, 1'b0); send(8'h00, 1'b0, 1'b0); send(8'h64, 1'b0, 1'b0);
    base_w = wen_cnt;
    for (int i = 0; i < 500; i++) send(8'h5A, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    chk("abort_err", o_err, 1);
    chk("abort_ready", o_ready, 1);
    send(8'h03, 1'b0, 1'b0); send(8'hFE, 1'b0, 1'b0);
    chk("abort_to_timeh", o_time, 1022);
    chk("abort_writes", wen_cnt - base_w, 333);
    base_t = twen_cnt;
    pulse_drq();
    chk("abort_no_busy", o_busy, 0);
    repeat (20) @(posedge i_clk);
    #1;
    chk("abort_no_commit", twen_cnt - base_t, 0);
    chk("abort_nt_partial", nt_mem[0], 12'h5A5);
    chk("abort_target_kept", t_mem[0], 12'h100);

    // Reset mid-copy
    send(8'hA5, 1'b1, 1'b0); send(8'h00, 1'b0, 1'b0); send(8'h64, 1'b0, 1'b0);
    send_frame(1'b0);
    pulse_drq();
    n = 0;
    while (o_raddr != 10'd300 && n < 2000) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk("reach_raddr300", o_raddr, 300);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_raddr", o_raddr, 0);
    chk("arst_twen", o_twen, 0);
    chk("arst_twaddr", o_twaddr, 0);
    chk("arst_twdata", o_twdata, 0);
    chk("arst_ttime", o_ttime, 0);
    chk("arst_time", o_time, 0);
    chk("arst_busy", o_busy, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("post_rst_ready", o_ready, 1);
    chk("post_rst_busy", o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
